// File: rtl/sgd_train_seq.sv
// Training sequencer for the SGD regression datapath: walks the sample RAM
// (row 0 = weights, rows 1..N = samples) and issues one-cycle phase strobes.
module sgd_train_seq #(
    parameter int ADDR_WIDTH  = 12,
    parameter int EPOCH_WIDTH = 8,
    parameter int RAM_LAT     = 1
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   hold,
    input  logic [ADDR_WIDTH-1:0]  data_points,
    input  logic [EPOCH_WIDTH-1:0] epoch,
    output logic                   busy,
    output logic                   done,
    output logic                   cfg_err,
    output logic                   ram_en,
    output logic [ADDR_WIDTH-1:0]  addr,
    output logic                   load_w,
    output logic                   fwd_en,
    output logic                   err_en,
    output logic                   bwd_en,
    output logic                   upd_en,
    output logic [ADDR_WIDTH-1:0]  sample_idx,
    output logic [EPOCH_WIDTH-1:0] epoch_cnt
);

    typedef enum logic [3:0] {
        IDLE, FETCHW, LOADW, FETCH, FWD, ERR, BWD, UPD, PAUSE, FIN
    } state_t;

    localparam logic [2:0] LAT_LAST = 3'(RAM_LAT - 1);

    state_t                 state_reg;
    logic [ADDR_WIDTH-1:0]  dp_reg;
    logic [EPOCH_WIDTH-1:0] ep_reg;
    logic [2:0]             lat_cnt_reg;

    logic                   last_sample;
    logic                   run_end;
    logic [ADDR_WIDTH-1:0]  idx_next;
    logic [EPOCH_WIDTH-1:0] ecnt_inc;

    // Position bookkeeping evaluated during UPD to pick the next sample/epoch.
    assign last_sample = (sample_idx >= dp_reg);
    assign idx_next    = last_sample ? ADDR_WIDTH'(1) : sample_idx + ADDR_WIDTH'(1);
    assign ecnt_inc    = epoch_cnt + EPOCH_WIDTH'(1);
    assign run_end     = last_sample && (ecnt_inc == ep_reg);

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_reg   <= IDLE;
            dp_reg      <= '0;
            ep_reg      <= '0;
            lat_cnt_reg <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            cfg_err     <= 1'b0;
            ram_en      <= 1'b0;
            addr        <= '0;
            load_w      <= 1'b0;
            fwd_en      <= 1'b0;
            err_en      <= 1'b0;
            bwd_en      <= 1'b0;
            upd_en      <= 1'b0;
            sample_idx  <= '0;
            epoch_cnt   <= '0;
        end else begin
            cfg_err <= 1'b0;
            ram_en  <= 1'b0;
            load_w  <= 1'b0;
            fwd_en  <= 1'b0;
            err_en  <= 1'b0;
            bwd_en  <= 1'b0;
            upd_en  <= 1'b0;

            if (abort && state_reg != IDLE) begin
                state_reg   <= IDLE;
                busy        <= 1'b0;
                sample_idx  <= '0;
                lat_cnt_reg <= '0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (start && !abort) begin
                            if (data_points == '0 || epoch == '0) begin
                                cfg_err <= 1'b1;
                            end else begin
                                dp_reg      <= data_points;
                                ep_reg      <= epoch;
                                done        <= 1'b0;
                                busy        <= 1'b1;
                                epoch_cnt   <= '0;
                                sample_idx  <= '0;
                                ram_en      <= 1'b1;
                                addr        <= '0;
                                lat_cnt_reg <= '0;
                                state_reg   <= FETCHW;
                            end
                        end
                    end
                    FETCHW: begin
                        if (lat_cnt_reg == LAT_LAST) begin
                            load_w     <= 1'b1;
                            sample_idx <= ADDR_WIDTH'(1);
                            state_reg  <= LOADW;
                        end else begin
                            lat_cnt_reg <= lat_cnt_reg + 3'd1;
                        end
                    end
                    LOADW: begin
                        if (hold) begin
                            state_reg <= PAUSE;
                        end else begin
                            ram_en      <= 1'b1;
                            addr        <= sample_idx;
                            lat_cnt_reg <= '0;
                            state_reg   <= FETCH;
                        end
                    end
                    FETCH: begin
                        // fwd_en must line up with the cycle the RAM word is valid.
                        if (lat_cnt_reg == LAT_LAST) begin
                            fwd_en    <= 1'b1;
                            state_reg <= FWD;
                        end else begin
                            lat_cnt_reg <= lat_cnt_reg + 3'd1;
                        end
                    end
                    FWD: begin
                        err_en    <= 1'b1;
                        state_reg <= ERR;
                    end
                    ERR: begin
                        bwd_en    <= 1'b1;
                        state_reg <= BWD;
                    end
                    BWD: begin
                        upd_en    <= 1'b1;
                        state_reg <= UPD;
                    end
                    UPD: begin
                        sample_idx <= idx_next;
                        if (last_sample) begin
                            epoch_cnt <= ecnt_inc;
                        end
                        if (run_end) begin
                            state_reg <= FIN;
                        end else if (hold) begin
                            state_reg <= PAUSE;
                        end else begin
                            ram_en      <= 1'b1;
                            addr        <= idx_next;
                            lat_cnt_reg <= '0;
                            state_reg   <= FETCH;
                        end
                    end
                    PAUSE: begin
                        if (!hold) begin
                            ram_en      <= 1'b1;
                            addr        <= sample_idx;
                            lat_cnt_reg <= '0;
                            state_reg   <= FETCH;
                        end
                    end
                    FIN: begin
                        done       <= 1'b1;
                        busy       <= 1'b0;
                        sample_idx <= '0;
                        state_reg  <= IDLE;
                    end
                    default: begin
                        state_reg <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sgd_train_seq.sv
// Randomized bench for sgd_train_seq: a per-cycle expected trace is generated
// from the run rules (fetch/strobe timing, hold windows, abort) and compared.
module tb_sgd_train_seq;
    localparam int AW = 12;
    localparam int EW = 8;

    localparam logic [8:0] F_BUSY = 9'h100;
    localparam logic [8:0] F_DONE = 9'h080;
    localparam logic [8:0] F_CFG  = 9'h040;
    localparam logic [8:0] F_RAM  = 9'h020;
    localparam logic [8:0] F_LW   = 9'h010;
    localparam logic [8:0] F_FWD  = 9'h008;
    localparam logic [8:0] F_ERR  = 9'h004;
    localparam logic [8:0] F_BWD  = 9'h002;
    localparam logic [8:0] F_UPD  = 9'h001;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, start, abort, hold;
    logic          sel3 = 1'b0;
    logic [AW-1:0] dp;
    logic [EW-1:0] ep;

    logic          busy1, done1, cfg_err1, ram_en1, load_w1, fwd1, err1, bwd1, upd1;
    logic [AW-1:0] addr1, idx1;
    logic [EW-1:0] ecnt1;
    logic          busy3, done3, cfg_err3, ram_en3, load_w3, fwd3, err3, bwd3, upd3;
    logic [AW-1:0] addr3, idx3;
    logic [EW-1:0] ecnt3;

    sgd_train_seq #(.ADDR_WIDTH(AW), .EPOCH_WIDTH(EW), .RAM_LAT(1)) dut1 (
        .CLK(clk), .RST_N(rst_n), .start(start & ~sel3), .abort(abort & ~sel3),
        .hold(hold & ~sel3), .data_points(dp), .epoch(ep),
        .busy(busy1), .done(done1), .cfg_err(cfg_err1), .ram_en(ram_en1), .addr(addr1),
        .load_w(load_w1), .fwd_en(fwd1), .err_en(err1), .bwd_en(bwd1), .upd_en(upd1),
        .sample_idx(idx1), .epoch_cnt(ecnt1)
    );

    sgd_train_seq #(.ADDR_WIDTH(AW), .EPOCH_WIDTH(EW), .RAM_LAT(3)) dut3 (
        .CLK(clk), .RST_N(rst_n), .start(start & sel3), .abort(abort & sel3),
        .hold(hold & sel3), .data_points(dp), .epoch(ep),
        .busy(busy3), .done(done3), .cfg_err(cfg_err3), .ram_en(ram_en3), .addr(addr3),
        .load_w(load_w3), .fwd_en(fwd3), .err_en(err3), .bwd_en(bwd3), .upd_en(upd3),
        .sample_idx(idx3), .epoch_cnt(ecnt3)
    );

    logic [8:0]    obs_flags;
    logic [AW-1:0] obs_addr, obs_idx;
    logic [EW-1:0] obs_ecnt;

    always_comb begin
        obs_flags = {busy1, done1, cfg_err1, ram_en1, load_w1, fwd1, err1, bwd1, upd1};
        obs_addr  = addr1;
        obs_idx   = idx1;
        obs_ecnt  = ecnt1;
        if (sel3) begin
            obs_flags = {busy3, done3, cfg_err3, ram_en3, load_w3, fwd3, err3, bwd3, upd3};
            obs_addr  = addr3;
            obs_idx   = idx3;
            obs_ecnt  = ecnt3;
        end
    end

    typedef struct packed {
        logic [8:0]    flags;
        logic [AW-1:0] addr;
        logic [AW-1:0] idx;
        logic          cnt_chk;
        logic [EW-1:0] ecnt;
    } exp_t;

    exp_t sched[$];
    int   checks = 0;
    int   errors = 0;
    int   hold_on = 0;
    int   hold_off = 0;
    logic model_done [2];

    // hold value driven during cycle k (seen by the DUT at the edge ending it)
    function automatic logic hold_at(input int k);
        return (k >= hold_on) && (k < hold_off);
    endfunction

    task automatic push(input logic [8:0] f, input int a, input int i, input logic chk, input int e);
        exp_t x;
        x.flags   = f;
        x.addr    = AW'(a);
        x.idx     = AW'(i);
        x.cnt_chk = chk;
        x.ecnt    = EW'(e);
        sched.push_back(x);
    endtask

    task automatic add_pause(input int nidx, input int necnt);
        int t;
        int k;
        t = sched.size() - 1;
        if (hold_at(t)) begin
            k = t + 1;
            while (hold_at(k)) k++;
            for (int p = t + 1; p <= k; p++) push(F_BUSY, 0, nidx, 1'b1, necnt);
        end
    endtask

    // Expected trace, one entry per cycle, entry 0 = cycle after the accepting edge.
    task automatic build(input int lat, input int n, input int e, input int ab);
        sched.delete();
        for (int i = 0; i < lat; i++) push(F_BUSY | ((i == 0) ? F_RAM : 9'h0), 0, 0, 1'b1, 0);
        push(F_BUSY | F_LW, 0, 1, 1'b0, 0);
        add_pause(1, 0);
        for (int ei = 0; ei < e; ei++) begin
            for (int s = 1; s <= n; s++) begin
                for (int i = 0; i < lat; i++) push(F_BUSY | ((i == 0) ? F_RAM : 9'h0), s, s, 1'b1, ei);
                push(F_BUSY | F_FWD, 0, s, 1'b1, ei);
                push(F_BUSY | F_ERR, 0, s, 1'b1, ei);
                push(F_BUSY | F_BWD, 0, s, 1'b1, ei);
                push(F_BUSY | F_UPD, 0, s, 1'b1, ei);
                if (!(s == n && ei == e - 1)) add_pause((s == n) ? 1 : s + 1, (s == n) ? ei + 1 : ei);
            end
        end
        push(F_BUSY, 0, 0, 1'b0, e);
        for (int i = 0; i < 4; i++) push(F_DONE, 0, 0, 1'b1, e);
        if (ab >= 0 && ab < sched.size() && sched[ab].flags[8]) begin
            while (sched.size() > ab + 1) void'(sched.pop_back());
            for (int i = 0; i < 3; i++) push(9'h0, 0, 0, 1'b0, 0);
        end
    endtask

    task automatic run_check(input string name, input logic use3, input int lat, input int n,
                             input int e, input int h_on, input int h_off, input int ab,
                             input int restart_at);
        exp_t x;
        hold_on  = h_on;
        hold_off = h_off;
        build(lat, n, e, ab);
        @(negedge clk);
        sel3 = use3; abort = 1'b0; hold = 1'b0;
        start = 1'b1; dp = AW'(n); ep = EW'(e);
        for (int t = 0; t < sched.size(); t++) begin
            @(posedge clk); #1;
            start = (t == restart_at);
            dp = AW'($urandom);
            ep = EW'($urandom);
            x = sched[t];
            checks++;
            if (obs_flags !== x.flags) begin
                errors++;
                $display("FAIL %s cyc %0d flags(busy,done,cfg,ram,lw,fwd,err,bwd,upd) got %b exp %b",
                         name, t, obs_flags, x.flags);
            end
            if (x.flags[5]) begin
                checks++;
                if (obs_addr !== x.addr) begin
                    errors++;
                    $display("FAIL %s cyc %0d addr got %0d exp %0d", name, t, obs_addr, x.addr);
                end
            end
            if (x.cnt_chk) begin
                checks++;
                if (obs_idx !== x.idx || obs_ecnt !== x.ecnt) begin
                    errors++;
                    $display("FAIL %s cyc %0d idx/epoch_cnt got %0d/%0d exp %0d/%0d",
                             name, t, obs_idx, obs_ecnt, x.idx, x.ecnt);
                end
            end
            hold  = hold_at(t);
            abort = (t == ab);
        end
        start = 1'b0; abort = 1'b0; hold = 1'b0;
        model_done[use3] = sched[sched.size() - 1].flags[7];
        $display("run %s lat=%0d n=%0d e=%0d hold=[%0d,%0d) abort@%0d cycles=%0d",
                 name, lat, n, e, h_on, h_off, ab, sched.size());
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0; start = 1'b1; dp = AW'(5); ep = EW'(1); abort = 1'b0; hold = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy1, done1, cfg_err1, ram_en1, load_w1, fwd1, err1, bwd1, upd1, addr1, idx1, ecnt1} !== '0) begin
            errors++;
            $display("FAIL reset lat1 outputs got %b/%0d/%0d/%0d exp 0", {busy1, done1, cfg_err1, ram_en1,
                     load_w1, fwd1, err1, bwd1, upd1}, addr1, idx1, ecnt1);
        end
        checks++;
        if ({busy3, done3, cfg_err3, ram_en3, load_w3, fwd3, err3, bwd3, upd3, addr3, idx3, ecnt3} !== '0) begin
            errors++;
            $display("FAIL reset lat3 outputs got %b/%0d/%0d/%0d exp 0", {busy3, done3, cfg_err3, ram_en3,
                     load_w3, fwd3, err3, bwd3, upd3}, addr3, idx3, ecnt3);
        end
        @(negedge clk);
        rst_n = 1'b1; start = 1'b0;
        model_done[0] = 1'b0;
        model_done[1] = 1'b0;
        $display("reset checked");
    endtask

    // Rejected starts (zero config) and start+abort in IDLE must leave the run state alone.
    task automatic test_cfg_err();
        logic [8:0] want;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            sel3 = 1'b0;
            start = 1'b1;
            abort = (k == 2);
            dp = (k == 0) ? AW'(0) : AW'($urandom_range(1, 50));
            ep = (k == 1) ? EW'(0) : EW'($urandom_range(1, 9));
            for (int t = 0; t < 4; t++) begin
                @(posedge clk); #1;
                start = 1'b0; abort = 1'b0;
                want = ((t == 0 && k != 2) ? F_CFG : 9'h0) | (model_done[0] ? F_DONE : 9'h0);
                checks++;
                if (obs_flags !== want) begin
                    errors++;
                    $display("FAIL cfg_err case %0d cyc %0d flags got %b exp %b", k, t, obs_flags, want);
                end
            end
            $display("cfg_err case %0d dp=%0d ep=%0d done=%0b", k, dp, ep, model_done[0]);
        end
    endtask

    task automatic test_reset_mid_upd();
        logic found;
        found = 1'b0;
        @(negedge clk);
        sel3 = 1'b0; start = 1'b1; dp = AW'(2); ep = EW'(1);
        for (int c = 0; c < 40 && !found; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (obs_flags[0]) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL reset_mid upd_en got 0 within 40 cycles exp 1");
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({obs_flags, obs_addr, obs_idx, obs_ecnt} !== '0) begin
            errors++;
            $display("FAIL reset_mid outputs got %b/%0d/%0d/%0d exp 0", obs_flags, obs_addr, obs_idx, obs_ecnt);
        end
        rst_n = 1'b1;
        model_done[0] = 1'b0;
        model_done[1] = 1'b0;
        $display("reset during UPD checked");
    endtask

    task automatic test_back_to_back();
        logic u3;
        int   n, e, hon, hoff, ab;
        for (int r = 0; r < 10; r++) begin
            u3   = 1'($urandom_range(0, 1));
            n    = $urandom_range(1, 5);
            e    = $urandom_range(1, 3);
            hon  = $urandom_range(0, 40);
            hoff = hon + $urandom_range(0, 6);
            ab   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 40) : -1;
            run_check("random", u3, u3 ? 3 : 1, n, e, hon, hoff, ab, -1);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; hold = 1'b0; dp = '0; ep = '0;
        model_done[0] = 1'b0;
        model_done[1] = 1'b0;
        test_reset();
        test_cfg_err();
        run_check("single_epoch", 1'b0, 1, 2, 1, 0, 0, -1, -1);
        test_cfg_err();
        run_check("multi_epoch", 1'b0, 1, 3, 2, 0, 0, -1, -1);
        run_check("hold", 1'b0, 1, 3, 1, 3, 8, -1, -1);
        run_check("abort_bwd", 1'b0, 1, 3, 1, 0, 0, 5, -1);
        run_check("after_abort", 1'b0, 1, 2, 1, 0, 0, -1, -1);
        test_reset_mid_upd();
        run_check("start_while_busy", 1'b0, 1, 2, 2, 0, 0, -1, 3);
        run_check("lat3", 1'b1, 3, 2, 1, 0, 0, -1, -1);
        run_check("lat3_hold", 1'b1, 3, 2, 2, 4, 12, -1, -1);
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
